// File: rtl/dreg_mem_sequencer.sv
// Moves one 256-bit distribution register to or from eight consecutive
// 32-bit memory words over a req/ack port.
module dreg_mem_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [4:0]        reg_idx,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              dreg_we,
    output logic [4:0]        dreg_wr_addr,
    output logic [255:0]      dreg_wr_data,
    output logic [4:0]        dreg_rd_addr,
    input  logic [255:0]      dreg_rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAP,
        S_XFER,
        S_WR_REG,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          beat_q;
    logic [2:0]          beat_d;
    logic [255:0]        buf_q;
    logic [255:0]        buf_d;
    logic                store_q;
    logic                store_d;
    logic [4:0]          idx_q;
    logic [4:0]          idx_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   base_d;
    logic                err_q;
    logic                err_d;
    logic [7:0]          bit_off;
    logic                misaligned;

    assign bit_off    = {beat_q, 5'd0};
    assign misaligned = (base_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            buf_q   <= '0;
            store_q <= 1'b0;
            idx_q   <= 5'd0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
            store_q <= store_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        store_d = store_q;
        idx_d   = idx_q;
        base_d  = base_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    store_d = is_store;
                    idx_d   = reg_idx;
                    base_d  = base_addr;
                    err_d   = misaligned;
                    beat_d  = 3'd0;
                    if (misaligned) begin
                        state_d = S_DONE;
                    end else if (is_store) begin
                        state_d = S_RD_WAIT;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_RD_WAIT: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                // Snapshot the whole register so the store is self-consistent
                buf_d   = dreg_rd_data;
                state_d = S_XFER;
            end
            S_XFER: begin
                if (mem_ack) begin
                    if (!store_q) begin
                        buf_d[bit_off +: 32] = mem_rdata;
                    end
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = store_q ? S_DONE : S_WR_REG;
                    end
                end
            end
            S_WR_REG: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign dreg_we      = (state_q == S_WR_REG);
    assign dreg_wr_addr = idx_q;
    assign dreg_wr_data = buf_q;
    assign dreg_rd_addr = idx_q;
    assign mem_req      = (state_q == S_XFER);
    assign mem_we       = store_q & mem_req;
    assign mem_addr     = base_q + ADDR_W'({beat_q, 2'b00});
    assign mem_wdata    = buf_q[bit_off +: 32];

endmodule

// File: tb/tb_dreg_mem_sequencer.sv
// Table-driven and randomized checks of dreg_mem_sequencer against a
// transfer-level model with a register file and a stalling memory.
module tb_dreg_mem_sequencer;

    typedef int stall_t[8];

    typedef struct {
        bit         st;
        logic [4:0] idx;
        logic [31:0] base;
        int         s0;
        int         s7;
        bit         plan;
        bit         spur;
        bit         noise;
        int         exp_done;
        bit         exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [4:0]   reg_idx;
    logic [31:0]  base_addr;
    logic         busy;
    logic         done;
    logic         err;
    logic         dreg_we;
    logic [4:0]   dreg_wr_addr;
    logic [255:0] dreg_wr_data;
    logic [4:0]   dreg_rd_addr;
    logic [255:0] rd_q;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    always #5 clk = ~clk;

    dreg_mem_sequencer #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_store     (is_store),
        .reg_idx      (reg_idx),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .dreg_we      (dreg_we),
        .dreg_wr_addr (dreg_wr_addr),
        .dreg_wr_data (dreg_wr_data),
        .dreg_rd_addr (dreg_rd_addr),
        .dreg_rd_data (rd_q),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // register file: one-cycle read latency, write-forwarded
    logic [255:0] rf [32];
    logic [255:0] rf_exp [32];
    logic         pre_we;
    logic [4:0]   pre_idx;
    logic [255:0] pre_data;

    always @(posedge clk) begin
        if (dreg_we) rf[dreg_wr_addr] <= dreg_wr_data;
        else if (pre_we) rf[pre_idx] <= pre_data;
        rd_q <= (dreg_we && dreg_wr_addr == dreg_rd_addr) ?
                dreg_wr_data : rf[dreg_rd_addr];
    end

    // transaction config, owned by the driver
    int           txn_id = 0;
    logic [31:0]  exp_base = '0;
    bit           exp_store = 1'b0;
    logic [255:0] exp_data = '0;
    stall_t       stl = '{default: 0};
    bit           plan = 1'b0;
    bit           noise = 1'b0;
    logic [31:0]  salt = 32'h1234_5678;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (plan) return 32'hA0 + ((a - exp_base) >> 2);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // memory responder and event recorder, owned by the monitor
    int           negcount = 0;
    int           seen_id = 0;
    int           beat_idx = 0;
    int           wait_left = 0;
    int           done_seen = 0;
    int           done_cnt = 0;
    int           we_seen = 0;
    int           we_cnt = 0;
    int           req_cyc = 0;
    int           ack_n = 0;
    int           beat_bad = 0;
    logic         err_at_done = 1'b0;
    logic [4:0]   we_addr = '0;
    logic [255:0] we_data = '0;

    initial mem_ack = 1'b0;
    initial mem_rdata = '0;

    always @(negedge clk) begin
        negcount++;
        if (txn_id != seen_id) begin
            seen_id   = txn_id;
            beat_idx  = 0;
            wait_left = stl[0];
            done_seen = 0;
            we_seen   = 0;
            req_cyc   = 0;
            ack_n     = 0;
            beat_bad  = 0;
        end
        if (done) begin
            done_seen++;
            done_cnt    = negcount;
            err_at_done = err;
        end
        if (dreg_we) begin
            we_seen++;
            we_cnt  = negcount;
            we_addr = dreg_wr_addr;
            we_data = dreg_wr_data;
        end
        mem_ack = 1'b0;
        if (mem_req) begin
            req_cyc++;
            if (beat_idx > 7) beat_bad++;
            else if (mem_addr !== exp_base + 32'(4 * beat_idx)) beat_bad++;
            else if (mem_we !== exp_store) beat_bad++;
            else if (exp_store && mem_wdata !== exp_data[beat_idx*32 +: 32])
                beat_bad++;
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = rd_fn(mem_addr);
                ack_n++;
                beat_idx++;
                wait_left = (beat_idx < 8) ? stl[beat_idx] : 0;
            end
        end else if (noise) begin
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
        end
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 256'(busy), 0);
        chk({tag, "_done"}, 256'(done), 0);
        chk({tag, "_err"}, 256'(err), 0);
        chk({tag, "_we"}, 256'(dreg_we), 0);
        chk({tag, "_req"}, 256'(mem_req), 0);
        chk({tag, "_mwe"}, 256'(mem_we), 0);
        chk({tag, "_addr"}, 256'(mem_addr), 0);
        chk({tag, "_wdata"}, 256'(mem_wdata), 0);
        chk({tag, "_wrdata"}, dreg_wr_data, 0);
        chk({tag, "_wraddr"}, 256'(dreg_wr_addr), 0);
        chk({tag, "_rdaddr"}, 256'(dreg_rd_addr), 0);
    endtask

    task automatic preload(input logic [4:0] idx, input logic [255:0] d);
        @(negedge clk); #1;
        pre_we      = 1'b1;
        pre_idx     = idx;
        pre_data    = d;
        rf_exp[idx] = d;
        @(negedge clk); #1;
        pre_we = 1'b0;
    endtask

    function automatic int model_done(input bit st, input logic [31:0] b,
                                      input stall_t s);
        int sum = 0;
        if (b[1:0] != 2'b00) return 1;
        foreach (s[i]) sum += s[i];
        return (st ? 11 : 10) + sum;
    endfunction

    task automatic run_xfer(input bit st, input logic [4:0] idx,
                            input logic [31:0] base, input stall_t s,
                            input bit pl, input bit spur, input bit nz,
                            input int exp_done, input bit exp_err);
        bit mis;
        int sum;
        int t0;
        int k;
        int bad;
        mis = (base[1:0] != 2'b00);
        sum = 0;
        foreach (s[i]) sum += s[i];
        @(negedge clk); #1;
        exp_base  = base;
        exp_store = st;
        stl       = s;
        plan      = pl;
        noise     = nz;
        if (st) exp_data = rf_exp[idx];
        else for (int i = 0; i < 8; i++)
            exp_data[i*32 +: 32] = rd_fn(base + 32'(4 * i));
        is_store  = st;
        reg_idx   = idx;
        base_addr = base;
        start     = 1'b1;
        txn_id++;
        t0 = negcount;
        @(negedge clk); #1;
        start     = 1'b0;
        is_store  = 1'($urandom);
        reg_idx   = 5'($urandom);
        base_addr = $urandom;
        if (spur && !mis) begin
            @(negedge clk); #1;
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (done_seen == 0 && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        @(negedge clk); #1;
        chk("done_count", 256'(done_seen), 1);
        chk("done_cycle", 256'(done_cnt - t0), 256'(exp_done));
        chk("err_at_done", 256'(err_at_done), 256'(exp_err));
        chk("busy_after", 256'(busy), 0);
        chk("err_held", 256'(err), 256'(exp_err));
        chk("ack_beats", 256'(ack_n), mis ? 0 : 8);
        chk("req_cycles", 256'(req_cyc), mis ? 0 : 256'(8 + sum));
        chk("beat_addr_data", 256'(beat_bad), 0);
        chk("we_pulses", 256'(we_seen), (!mis && !st) ? 1 : 0);
        if (!mis && !st) begin
            chk("we_cycle", 256'(we_cnt - t0), 256'(exp_done - 1));
            chk("we_addr", 256'(we_addr), 256'(idx));
            chk("we_data", we_data, exp_data);
            rf_exp[idx] = exp_data;
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== rf_exp[i]) bad++;
        chk("rf_contents", 256'(bad), 0);
    endtask

    vec_t   tbl[9];
    stall_t s;

    initial begin
        logic [255:0] d;
        int k;
        int bad;
        rst = 1'b1;
        start = 1'b0;
        is_store = 1'b0;
        reg_idx = '0;
        base_addr = '0;
        pre_we = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        tbl[0] = '{1, 5'd5,  32'h0000_0200, 0, 0, 0, 0, 0, 11, 0};
        tbl[1] = '{0, 5'd31, 32'h0000_0100, 0, 0, 1, 0, 0, 10, 0};
        tbl[2] = '{0, 5'd7,  32'h0000_0300, 2, 2, 0, 0, 0, 14, 0};
        tbl[3] = '{1, 5'd4,  32'h0000_0202, 0, 0, 0, 0, 0, 1,  1};
        tbl[4] = '{0, 5'd2,  32'h0000_0400, 0, 0, 0, 0, 1, 10, 0};
        tbl[5] = '{1, 5'd5,  32'h0000_0600, 0, 0, 0, 1, 0, 11, 0};
        tbl[6] = '{1, 5'd31, 32'hFFFF_FFF0, 1, 0, 0, 0, 1, 12, 0};
        tbl[7] = '{0, 5'd3,  32'h0000_0003, 0, 0, 0, 0, 0, 1,  1};
        tbl[8] = '{0, 5'd5,  32'hFFFF_FFF8, 0, 0, 1, 0, 0, 10, 0};

        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk); #1;
        chk_quiet("post_reset");

        for (int r = 0; r < 32; r++) begin
            for (int w = 0; w < 8; w++)
                d[w*32 +: 32] = (r == 5) ? 32'h1000_0000 + 32'(w) : $urandom;
            preload(5'(r), d);
        end

        foreach (tbl[i]) begin
            s = '{default: 0};
            s[0] = tbl[i].s0;
            s[7] = tbl[i].s7;
            run_xfer(tbl[i].st, tbl[i].idx, tbl[i].base, s, tbl[i].plan,
                     tbl[i].spur, tbl[i].noise, tbl[i].exp_done,
                     tbl[i].exp_err);
        end

        // reset lands on the beat-4 ack of a load
        @(negedge clk); #1;
        exp_base  = 32'h0000_0800;
        exp_store = 1'b0;
        stl       = '{default: 0};
        plan      = 1'b0;
        noise     = 1'b0;
        is_store  = 1'b0;
        reg_idx   = 5'd9;
        base_addr = 32'h0000_0800;
        start     = 1'b1;
        txn_id++;
        @(negedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(mem_ack && beat_idx == 5) && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chk("beat4_reached", 256'(beat_idx), 5);
        #1 rst = 1'b1;
        #1;
        chk_quiet("abort");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_we", 256'(we_seen), 0);
        chk("abort_done", 256'(done_seen), 0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== rf_exp[i]) bad++;
        chk("abort_rf", 256'(bad), 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] b;
            bit st;
            b = $urandom;
            if ($urandom_range(0, 5) != 0) b[1:0] = 2'b00;
            st = 1'($urandom);
            foreach (s[i]) s[i] = $urandom_range(0, 2);
            @(negedge clk); #1;
            salt = $urandom;
            run_xfer(st, 5'($urandom), b, s, 1'b0, 1'($urandom),
                     1'($urandom), model_done(st, b, s),
                     b[1:0] != 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dreg_mem_sequencer.md
# dreg_mem_sequencer

Sequences block transfers between one 256-bit distribution register and 32-bit data memory. A load or store moves eight words over a req/ack memory port. The block owns the distribution register file's write port and one read port while busy. The core starts it with a one-cycle `start` pulse and sees completion on `done`.

## Interface
- `ADDR_W`, default 32: memory byte-address width.
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin transfer; accepted only in IDLE.
- `is_store`  in  1: 1 = register→memory, 0 = memory→register; sampled with `start`.
- `reg_idx`  in  5: distribution register index; sampled with `start`.
- `base_addr`  in  ADDR_W: byte address of word 0; sampled with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: misaligned `base_addr`; held until next accepted `start`.
- `dreg_we`  out  1: register file write enable.
- `dreg_wr_addr`  out  5: register file write index (= latched `reg_idx`).
- `dreg_wr_data`  out  256: register file write data (= assembly buffer).
- `dreg_rd_addr`  out  5: register file read index (= latched `reg_idx`).
- `dreg_rd_data`  in  256: read data, valid the cycle after the read address is sampled by the register file (one-cycle read latency, write-forwarded).
- `mem_req`  out  1: memory beat request.
- `mem_we`  out  1: 1 = write beat (store), 0 = read beat (load).
- `mem_addr`  out  ADDR_W: `base_addr + 4*beat`.
- `mem_wdata`  out  32: `buf[32*beat+31 : 32*beat]`.
- `mem_ack`  in  1: beat complete; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: read data.

## Operation
- States: IDLE, RD_WAIT, RD_CAP, XFER, WR_REG, DONE.
- IDLE: on `start`=1, latch `is_store`, `reg_idx`, and `base_addr`; clear `err`; clear the 3-bit beat counter.
  - If `base_addr[1:0]`≠0: set `err`=1 and go to DONE. No memory or register traffic occurs.
  - Otherwise, a store goes to RD_WAIT and a load goes to XFER.
- RD_WAIT: the register file samples `dreg_rd_addr` this cycle. Go to RD_CAP.
- RD_CAP: `buf` ← `dreg_rd_data` (256-bit snapshot). Go to XFER. Later writes to that register do not affect the stored data.
- XFER: `mem_req`=1, and `mem_addr`, `mem_we`, and `mem_wdata` are held stable until `mem_ack`.
  - On `mem_ack`, for a load: `buf[32*beat+:32]` ← `mem_rdata`.
  - On `mem_ack`, the beat counter increments.
  - On the ack of beat 7: a load goes to WR_REG and a store goes to DONE. Otherwise the block stays in XFER and `mem_req` stays high with the next beat's address.
- WR_REG: `dreg_we`=1 for exactly this cycle, with the fully assembled `buf`. Go to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.
- Word order is little-endian by index: word i = bits [32i+31:32i] at `base_addr+4i`. Address arithmetic is modulo 2^ADDR_W.
- The register file is written only in WR_REG. A partial load never modifies any register.
- `start` while not IDLE is ignored; it is not queued.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset (async assert, any state): state = IDLE and `buf` = 0. `busy`, `done`, `err`, `dreg_we`, `mem_req`, and `mem_we` are 0. `mem_addr`, `mem_wdata`, `dreg_wr_data`, `dreg_wr_addr`, and `dreg_rd_addr` are 0.
- Reset mid-transfer aborts the transfer immediately. No `done` is produced and no register write occurs.
- Cycle numbering: `start` is sampled at edge 0, and the cycle after edge 0 is cycle 1.
- Load with zero-wait memory (ack in same cycle as req): XFER in cycles 1–8, `dreg_we` in cycle 9, `done` in cycle 10, `busy` low in cycle 11.
- Store with zero-wait memory: RD_WAIT in cycle 1, RD_CAP in cycle 2, XFER in cycles 3–10, `done` in cycle 11.
- Each cycle in XFER without ack adds exactly one cycle to the latency.
- Misaligned request: `done`=1 and `err`=1 in cycle 1.
- A new `start` is accepted in the first IDLE cycle after DONE. Back-to-back transfers therefore have one idle cycle between them.

## Test plan
- Store, zero-wait: preload reg 5 with word i = 0x1000_0000+i and issue `start`, `is_store`=1, `base_addr`=0x200. Required: memory writes at 0x200..0x21C with values 0x1000_0000..0x1000_0007, `done` in cycle 11, `dreg_we` never asserted.
- Load, zero-wait: memory returns 0xA0+i for beat i, with `reg_idx`=31. Required: a single `dreg_we` pulse in cycle 9 to address 31, with data word i = 0xA0+i, then `done` in cycle 10.
- Memory stalls: ack is delayed 2 cycles on beats 0 and 7 of a load. Required: `mem_addr` is stable during each stall, the write data is correct, and `done` arrives in cycle 14.
- Misaligned request: `base_addr`=0x202. Required: `done` and `err` in cycle 1 with no `mem_req` or `dreg_we`. `err` clears on the next aligned `start`.
- Reset on the beat-4 ack of a load. Required: all outputs 0 immediately, no `dreg_we`, and the target register is unchanged.
- `start` pulsed during a busy store. Required: it is ignored and the original transfer completes unchanged.
